// File: rtl/buf_pipe_elastic.sv
// buf_pipe_elastic: WIDTH-bit, DEPTH-stage elastic register pipe with
// per-beat optional inversion under INV_MASK. Empty stages always pull from
// the stage behind them, so bubbles collapse even while the output stalls.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake, in_data beat, inv_en per-beat invert
//   out_valid/out_ready downstream handshake, out_data output-stage data
//   flush             synchronous discard of every held beat
//   count             number of occupied stages, 0..DEPTH

// One pipe stage: loads from its source when allowed to advance. Data only
// changes when the source holds a real beat, so bubbles never toggle d.
module buf_pipe_elastic_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             src_v,
    input  logic [WIDTH-1:0] src_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (adv) begin
            v <= src_v;
            if (src_v) d <= src_d;
        end
    end
endmodule

module buf_pipe_elastic #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       inv_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("buf_pipe_elastic: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic                        in_xfer;
    logic                        out_xfer;

    // Ready ripples from the output end: a stage can load if it is empty or
    // the stage ahead of it is also moving.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == DEPTH-1) begin : g_last
            assign rdy[i] = ~v[i] | out_ready;
        end else begin : g_mid
            assign rdy[i] = ~v[i] | rdy[i+1];
        end

        if (i == 0) begin : g_head
            assign src_v[i] = in_valid;
            assign src_d[i] = in_data ^ (inv_en ? INV_MASK : {WIDTH{1'b0}});
        end else begin : g_body
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
        end

        buf_pipe_elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .adv   (rdy[i]),
            .src_v (src_v[i]),
            .src_d (src_d[i]),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Occupancy kept as its own counter; it tracks popcount(v) exactly.
    always_ff @(posedge clk) begin
        if (rst || flush) count <= '0;
        else              count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
endmodule

// File: doc/buf_pipe_elastic.md
Name: buf_pipe_elastic

Overview:
- Parametrised successor to the BUF/INV cell family: a WIDTH-bit, DEPTH-stage registered buffer chain with optional runtime inversion under a bit mask.
- Bubble-collapsing stages, valid/ready handshake on both sides, synchronous flush, live occupancy count.
- Used as a drop-in retiming/repeater pipe on long datapath routes (e.g. between fetch, decode and memory blocks) where a plain buffer cell cannot meet timing.

Parameters:
- WIDTH, 32, data bits per beat (≥1).
- DEPTH, 3, number of register stages (≥1; DEPTH=0 is illegal and fails elaboration).
- INV_MASK, {WIDTH{1'b1}}, bits inverted when inv_en=1; bits with mask 0 pass through buffered.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  pipe can accept a beat this cycle.
- in_data  in  WIDTH  upstream data.
- inv_en  in  1  sampled with each accepted beat; selects inversion under INV_MASK.
- out_valid  out  1  output stage holds a beat.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  output stage data.
- flush  in  1  synchronous discard of all held beats.
- count  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- State: per stage i (0..DEPTH-1) a valid bit v[i] and data d[i]. Stage DEPTH-1 is the output stage.
  - out_valid = v[DEPTH-1] & ~flush.
  - out_data = d[DEPTH-1].
- Ready chain (combinational, computed from the output end backwards):
  - rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - rdy[i] = ~v[i] | rdy[i+1].
  - in_ready = rdy[0] & ~flush.
- Advance on posedge with rst=0 and flush=0, for every stage i with rdy[i]=1:
  - Stage 0: v[0] <= in_valid. If in_valid=1, d[0] <= in_data ^ (inv_en ? INV_MASK : 0).
  - Stage i>0: v[i] <= v[i-1]. If v[i-1]=1, d[i] <= d[i-1].
  - d[i] holds whenever its source is not valid (no toggling on bubbles).
  - Stages with rdy[i]=0 hold both v and d.
- Bubbles collapse: an empty stage always accepts from the stage before it, even while the output stage is stalled.
- Latency and throughput:
  - Accepted beat appears on out_valid exactly DEPTH cycles later when there are no stalls.
  - Sustained throughput is 1 beat/cycle.
  - Beats leave strictly in acceptance order.
- inv_en is per-beat. Changing it mid-stream affects only beats accepted after the change.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready may depend combinationally on out_ready; out_valid never depends on in_valid.
- Full: count=DEPTH with out_ready=0 gives in_ready=0 and all state held. With out_ready=1 at count=DEPTH, in_ready=1 and simultaneous in/out transfers are allowed; count stays DEPTH.
- Empty: count=0 gives out_valid=0 and in_ready=1.
- count, next value = count + (in xfer) − (out xfer). It is a registered counter and must equal popcount(v) at all times (bench assertion).
- flush=1:
  - Next cycle all v=0 and count=0.
  - In the flush cycle, in_ready=0 and out_valid=0, so no transfer occurs on either side.
  - d registers hold their values.
- Reset (rst=1): next posedge all v=0, all d=0, count=0. Hence after reset out_valid=0, out_data=0, in_ready=1.
  - Reset mid-stream discards all beats.
  - rst has priority over flush and over any handshake.

Test Plan (WIDTH=8, DEPTH=3, INV_MASK=8'h0F):
- Reset then stream 8'h11,8'h22,8'h33 with inv_en=0, out_ready=1 -> out_valid rises 3 cycles after first accept; outputs 11,22,33 on consecutive cycles; count peaks at 3.
- Accept 8'hA5 with inv_en=1, then 8'hA5 with inv_en=0 -> out_data 8'hAA then 8'hA5.
- out_ready=0, push 5 beats 01..05 -> 3 accepted, in_ready=0 with count=3. Raise out_ready for 1 cycle -> 01 out, 04 accepted same cycle, count stays 3.
- Load stage 0 only, stall output with v[2]=1 and v[1]=0 -> beat moves to stage 1 next cycle (bubble collapse), count unchanged.
- Pipe holding 2 beats, assert flush with in_valid=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0 and out_valid=0; injected beat never emerges.
- rst asserted at count=2 with in_valid=1 -> next cycle count=0, out_data=8'h00, in_ready=1; no pre-reset beat is ever output.
